// File: rtl/pipelined_adder.sv
// pipelined_adder: chunked ripple-carry adder with a valid/ready handshake. Each stage adds one chunk.
// When the PIPE_ADDER_SUB_EN macro is defined, `sub` selects x - y - ci. Otherwise `sub` is ignored.
module pipelined_adder #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             ci,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             co,
    output logic             ovf
);
    localparam int CW = WIDTH / STAGES;

    logic [WIDTH-1:0]  y_eff;
    logic              c_eff;
    logic              stall;
    logic              adv;
    logic [STAGES-1:0] valid_d;
    logic [STAGES-1:0] valid_q;
    logic [STAGES-1:0] carry_d;
    logic [STAGES-1:0] carry_q;
    logic              ovf_d;
    logic              ovf_q;

`ifdef PIPE_ADDER_SUB_EN
    assign y_eff = y ^ {WIDTH{sub}};
    assign c_eff = ci ^ sub;
`else
    logic sub_unused;
    assign sub_unused = sub;
    assign y_eff      = y;
    assign c_eff      = ci;
`endif

    assign stall    = out_valid & ~out_ready;
    assign adv      = ~stall;
    assign in_ready = ~stall;

    genvar gi;
    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_stage
            // xs/ys carry the operand bits not yet consumed. Their low chunk is summed here.
            // sum_q accumulates the finished low chunks.
            localparam int OW = WIDTH - gi * CW;
            localparam int SW = (gi + 1) * CW;

            logic [OW-1:0] xs;
            logic [OW-1:0] ys;
            logic          cin;
            logic [CW:0]   full;
            logic [SW-1:0] sum_d;
            logic [SW-1:0] sum_q;

            if (gi == 0) begin : g_head
                assign xs          = x;
                assign ys          = y_eff;
                assign cin         = c_eff;
                assign valid_d[gi] = in_valid;
                always_comb begin
                    sum_d = full[CW-1:0];
                end
            end else begin : g_body
                logic [OW-1:0] xs_d;
                logic [OW-1:0] xs_q;
                logic [OW-1:0] ys_d;
                logic [OW-1:0] ys_q;

                always_comb begin
                    xs_d  = g_stage[gi-1].xs[OW+CW-1:CW];
                    ys_d  = g_stage[gi-1].ys[OW+CW-1:CW];
                    sum_d = {full[CW-1:0], g_stage[gi-1].sum_q};
                end

                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        xs_q <= '0;
                        ys_q <= '0;
                    end else if (adv) begin
                        xs_q <= xs_d;
                        ys_q <= ys_d;
                    end
                end

                assign xs          = xs_q;
                assign ys          = ys_q;
                assign cin         = carry_q[gi-1];
                assign valid_d[gi] = valid_q[gi-1];
            end

            always_comb begin
                full = {1'b0, xs[CW-1:0]} + {1'b0, ys[CW-1:0]} + {{CW{1'b0}}, cin};
            end

            assign carry_d[gi] = full[CW];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    sum_q <= '0;
                end else if (adv) begin
                    sum_q <= sum_d;
                end
            end
        end
    endgenerate

    // The carry into the MSB is recovered from the MSB sum bit: sum ^ a ^ b.
    assign ovf_d = g_stage[STAGES-1].full[CW-1] ^ g_stage[STAGES-1].xs[CW-1]
                 ^ g_stage[STAGES-1].ys[CW-1] ^ carry_d[STAGES-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            carry_q <= '0;
            ovf_q   <= 1'b0;
        end else if (adv) begin
            valid_q <= valid_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
        end
    end

    assign out_valid = valid_q[STAGES-1];
    assign co        = carry_q[STAGES-1];
    assign ovf       = ovf_q;
    assign s         = g_stage[STAGES-1].sum_q;

endmodule

// File: tb/tb_pipelined_adder.sv
// Testbench for pipelined_adder. A scoreboard queue holds the expected results.
// Results are pushed when a beat is accepted and popped when a beat leaves the adder.
`timescale 1ns/1ps
module tb_pipelined_adder;
    localparam int WIDTH  = 8;
    localparam int STAGES = 2;

    typedef struct packed {
        logic [WIDTH-1:0] s;
        logic             co;
        logic             ovf;
    } res_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] x = '0;
    logic [WIDTH-1:0] y = '0;
    logic             ci = 1'b0;
    logic             sub = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] s;
    logic             co;
    logic             ovf;

    res_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    pipelined_adder #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .x(x), .y(y), .ci(ci), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .s(s), .co(co), .ovf(ovf)
    );

    function automatic res_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                   input logic c, input logic sb);
        logic             se;
        logic [WIDTH-1:0] be;
        logic [WIDTH:0]   t;
        res_t             r;
`ifdef PIPE_ADDER_SUB_EN
        se = sb;
`else
        se = sb & 1'b0;
`endif
        be    = se ? ~b : b;
        t     = {1'b0, a} + {1'b0, be} + (WIDTH+1)'(c ^ se);
        r.s   = t[WIDTH-1:0];
        r.co  = t[WIDTH];
        r.ovf = (a[WIDTH-1] == be[WIDTH-1]) && (r.s[WIDTH-1] != a[WIDTH-1]);
        return r;
    endfunction

    // Applies inputs on the falling edge, then lets the combinational in_ready settle.
    task automatic drive(input logic v, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic c, input logic sb, input logic rdy);
        @(negedge clk);
        in_valid  = v;
        x         = a;
        y         = b;
        ci        = c;
        sub       = sb;
        out_ready = rdy;
        #1;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        #1;
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_out_valid: got %b, required 0", out_valid);
        end
        n_checks++;
        if (s !== '0) begin
            n_fail++; $display("FAIL reset_s: got %h, required 00", s);
        end
        n_checks++;
        if (co !== 1'b0 || ovf !== 1'b0) begin
            n_fail++; $display("FAIL reset_flags: got co=%b ovf=%b, required co=0 ovf=0", co, ovf);
        end
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_in_ready: got %b, required 1", in_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        $display("reset: released");
    endtask

    task automatic test_directed();
        logic [WIDTH-1:0] tx [4];
        logic [WIDTH-1:0] ty [4];
        logic             tc [4];
        logic             tsb [4];
        res_t             tex [4];
        res_t             e;
        tx[0] = 8'h5A; ty[0] = 8'h33; tc[0] = 1'b0; tsb[0] = 1'b0; tex[0] = '{s: 8'h8D, co: 1'b0, ovf: 1'b1};
        tx[1] = 8'h0F; ty[1] = 8'h01; tc[1] = 1'b0; tsb[1] = 1'b0; tex[1] = '{s: 8'h10, co: 1'b0, ovf: 1'b0};
        tx[2] = 8'hFF; ty[2] = 8'h00; tc[2] = 1'b1; tsb[2] = 1'b0; tex[2] = '{s: 8'h00, co: 1'b1, ovf: 1'b0};
        tx[3] = 8'h10; ty[3] = 8'h20; tc[3] = 1'b0; tsb[3] = 1'b1;
`ifdef PIPE_ADDER_SUB_EN
        tex[3] = '{s: 8'hF0, co: 1'b0, ovf: 1'b0};
`else
        tex[3] = '{s: 8'h30, co: 1'b0, ovf: 1'b0};
`endif
        for (int i = 0; i < 4 + 20 && (i < 4 || exp_q.size() != 0); i++) begin
            if (i < 4) drive(1'b1, tx[i], ty[i], tc[i], tsb[i], 1'b1);
            else       drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
            if (out_valid && out_ready) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++; $display("FAIL directed_extra: unexpected beat s=%h, required none", s);
                end else begin
                    e = exp_q.pop_front();
                    if ({s, co, ovf} !== e) begin
                        n_fail++;
                        $display("FAIL directed_result: got s=%h co=%b ovf=%b, required s=%h co=%b ovf=%b",
                                 s, co, ovf, e.s, e.co, e.ovf);
                    end else begin
                        $display("directed: s=%h co=%b ovf=%b", s, co, ovf);
                    end
                end
            end
            if (in_valid && in_ready && i < 4) exp_q.push_back(tex[i]);
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++; $display("FAIL directed_drain: %0d beats outstanding, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_back_to_back();
        res_t e;
        int   got   = 0;
        int   first = 0;
        for (int i = 0; i < 16 + 20 && (i < 16 || exp_q.size() != 0); i++) begin
            if (i < 16) drive(1'b1, WIDTH'($urandom), WIDTH'($urandom), 1'($urandom_range(0, 1)),
                              1'($urandom_range(0, 1)), 1'b1);
            else        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
            if (out_valid && out_ready) begin
                if (got == 0) first = cyc;
                n_checks++;
                if (cyc != first + got) begin
                    n_fail++; $display("FAIL b2b_gap: beat %0d at cycle %0d, required %0d", got, cyc, first + got);
                end
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++; $display("FAIL b2b_extra: unexpected beat s=%h, required none", s);
                end else begin
                    e = exp_q.pop_front();
                    if ({s, co, ovf} !== e) begin
                        n_fail++;
                        $display("FAIL b2b_result: beat %0d got s=%h co=%b ovf=%b, required s=%h co=%b ovf=%b",
                                 got, s, co, ovf, e.s, e.co, e.ovf);
                    end else begin
                        $display("b2b: beat %0d s=%h co=%b ovf=%b", got, s, co, ovf);
                    end
                end
                got++;
            end
            if (in_valid && in_ready) exp_q.push_back(model(x, y, ci, sub));
        end
        n_checks++;
        if (got != 16 || exp_q.size() != 0) begin
            n_fail++; $display("FAIL b2b_count: got %0d beats, required 16", got);
            exp_q.delete();
        end
    endtask

    task automatic test_backpressure();
        res_t e;
        int   got = 0;
        drive(1'b1, 8'h81, 8'h92, 1'b0, 1'b0, 1'b0);
        if (in_valid && in_ready) exp_q.push_back(model(x, y, ci, sub));
        drive(1'b1, 8'h7F, 8'h01, 1'b1, 1'b0, 1'b0);
        if (in_valid && in_ready) exp_q.push_back(model(x, y, ci, sub));
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 8'hC3, 8'h3C, 1'b0, 1'b0, 1'b0);
            n_checks++;
            if (in_ready !== 1'b0) begin
                n_fail++; $display("FAIL bp_in_ready: got %b, required 0", in_ready);
            end
            n_checks++;
            if (out_valid !== 1'b1) begin
                n_fail++; $display("FAIL bp_out_valid: got %b, required 1", out_valid);
            end
            n_checks++;
            if ({s, co, ovf} !== exp_q[0]) begin
                n_fail++;
                $display("FAIL bp_frozen: got s=%h co=%b ovf=%b, required s=%h co=%b ovf=%b",
                         s, co, ovf, exp_q[0].s, exp_q[0].co, exp_q[0].ovf);
            end else begin
                $display("bp: stalled cycle %0d s=%h", k, s);
            end
            if (in_valid && in_ready) exp_q.push_back(model(x, y, ci, sub));
        end
        for (int k = 0; k < 20 && exp_q.size() != 0; k++) begin
            drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
            if (out_valid && out_ready) begin
                n_checks++;
                e = exp_q.pop_front();
                if ({s, co, ovf} !== e) begin
                    n_fail++;
                    $display("FAIL bp_result: got s=%h co=%b ovf=%b, required s=%h co=%b ovf=%b",
                             s, co, ovf, e.s, e.co, e.ovf);
                end else begin
                    $display("bp: delivered s=%h co=%b ovf=%b", s, co, ovf);
                end
                got++;
            end
        end
        n_checks++;
        if (got != 2 || exp_q.size() != 0) begin
            n_fail++; $display("FAIL bp_count: delivered %0d beats, required 2", got);
            exp_q.delete();
        end
    endtask

    task automatic test_reset_flush();
        res_t e;
        int   lat  = 0;
        bit   seen = 1'b0;
        drive(1'b1, 8'h11, 8'h22, 1'b0, 1'b0, 1'b1);
        if (in_valid && in_ready) exp_q.push_back(model(x, y, ci, sub));
        drive(1'b1, 8'h33, 8'h44, 1'b1, 1'b0, 1'b1);
        if (in_valid && in_ready) exp_q.push_back(model(x, y, ci, sub));
        @(negedge clk);
        rst      = 1'b1;
        in_valid = 1'b0;
        #1;
        exp_q.delete();
        n_checks++;
        if (out_valid !== 1'b0 || s !== '0 || co !== 1'b0 || ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_outputs: got v=%b s=%h co=%b ovf=%b, required all 0", out_valid, s, co, ovf);
        end
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL flush_in_ready: got %b, required 1", in_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
            n_checks++;
            if (out_valid !== 1'b0) begin
                n_fail++; $display("FAIL flush_ghost: got out_valid=%b, required 0", out_valid);
            end
        end
        $display("flush: in-flight beats discarded");
        drive(1'b1, 8'h5A, 8'h33, 1'b0, 1'b0, 1'b1);
        if (in_valid && in_ready) exp_q.push_back(model(x, y, ci, sub));
        for (int k = 0; k < 20 && !seen; k++) begin
            drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
            lat++;
            if (out_valid && out_ready) begin
                seen = 1'b1;
                n_checks++;
                e = exp_q.pop_front();
                if ({s, co, ovf} !== e) begin
                    n_fail++;
                    $display("FAIL flush_result: got s=%h co=%b ovf=%b, required s=%h co=%b ovf=%b",
                             s, co, ovf, e.s, e.co, e.ovf);
                end
            end
        end
        n_checks++;
        if (!seen || lat != STAGES) begin
            n_fail++; $display("FAIL flush_latency: got %0d cycles (seen=%b), required %0d", lat, seen, STAGES);
        end else begin
            $display("flush: first beat after release in %0d cycles", lat);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_backpressure();
        test_reset_flush();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipelined_adder.md
# pipelined_adder

Parametrised, pipelined ripple-carry adder/subtractor with a valid/ready handshake. The `WIDTH`-bit operation is split into `STAGES` equal chunks. Each pipeline stage adds one chunk and registers its carry into the next stage, so throughput is one operation per cycle at any width. It is the general-width, registered successor to the combinational one- and two-bit full adders and sits between operand producers and downstream arithmetic consumers.

## Interface
Parameters:
- `WIDTH`, 8, operand and sum width in bits; must be a multiple of `STAGES`.
- `STAGES`, 2, pipeline depth and number of chunks; chunk width `CW = WIDTH/STAGES`, `1 <= STAGES <= WIDTH`.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `in_valid`  in  1  operand beat present.
- `in_ready`  out  1  block accepts operand beat this cycle.
- `x`  in  WIDTH  operand A, unsigned or two's complement.
- `y`  in  WIDTH  operand B.
- `ci`  in  1  carry-in (borrow-in in subtract mode).
- `sub`  in  1  1 = subtract (only effective with `PIPE_ADDER_SUB_EN`).
- `out_valid`  out  1  result beat present.
- `out_ready`  in  1  consumer accepts result beat.
- `s`  out  WIDTH  sum/difference.
- `co`  out  1  carry-out of MSB (in subtract mode, 1 = no borrow).
- `ovf`  out  1  signed overflow: carry into MSB XOR carry out of MSB.

## Operation
- Effective operands:
  - `y_eff = y ^ {WIDTH{sub_e}}`
  - `c_eff = ci ^ sub_e`
  - `sub_e` = `sub` when the macro is defined, otherwise 0.
- Stage k (0..STAGES-1) computes chunk k as `x[k] + y_eff[k] + carry_k`.
  - `carry_0 = c_eff`.
  - `carry_k` for k>0 is the registered carry-out of stage k-1 for the same beat.
- Skew registers delay the upper operand chunks so that chunk k reaches stage k exactly k cycles after acceptance.
- Deskew registers delay the lower sum chunks so that all chunks of a beat appear on `s` together.
- Final stage result:
  - `co` = carry out of the MSB.
  - `ovf` = carry into the MSB XOR `co`, computed inside the last chunk.
- Each stage has a valid bit. Beats never reorder, merge or drop.
- Stall rule: `stall = out_valid & ~out_ready`.
  - When `stall` = 1, every pipeline register, valid bit and output holds.
  - `in_ready = ~stall`. This rule is combinational and intentionally conservative; bubbles are not collapsed.
- Acceptance: a beat is accepted when `in_valid & in_ready`. If `in_valid` = 0 and there is no stall, a bubble (valid=0) enters.
- Arithmetic wraps modulo 2^WIDTH; no saturation.
- `STAGES` = 1 degenerates to a single registered ripple adder.

## Timing
- Reset values: `out_valid`=0, `s`=0, `co`=0, `ovf`=0, all internal valid bits and carries 0. `in_ready`=1 while `rst` is high, because `out_valid`=0 forces `stall`=0.
- Reset asserted mid-operation discards all in-flight beats immediately, with no output pulse. The first accept after release is on the first rising edge with `rst` low.
- Latency: a beat accepted at edge n appears with `out_valid`=1 after edge n+STAGES-1, i.e. it is registered through STAGES flops.
- Throughput: 1 beat/cycle while `out_ready`=1.
- Simultaneous accept and output transfer in the same cycle is allowed and required for full throughput.
- Outputs are stable while `out_valid & ~out_ready`. `s`, `co` and `ovf` are don't-care when `out_valid`=0 but must not be X after reset.

## Configuration
- `PIPE_ADDER_SUB_EN`:
  - Defined: `sub` selects subtraction. The result is `x - y - ci` modulo 2^WIDTH, `co` = NOT borrow, and `ovf` is the signed subtract overflow.
  - Undefined: `sub` is ignored (port kept, tied off internally), no XOR logic is built, and the block is add-only.

## Test plan
- WIDTH=8, STAGES=2, reset released, `x`=0x5A, `y`=0x33, `ci`=0 -> after 2 cycles `s`=0x8D, `co`=0, `ovf`=1.
- Carry across chunk boundary: `x`=0x0F, `y`=0x01, `ci`=0 -> `s`=0x10, `co`=0. Then `x`=0xFF, `y`=0x00, `ci`=1 -> `s`=0x00, `co`=1, `ovf`=0.
- Back-to-back stream of 16 random beats with `out_ready`=1 -> 16 consecutive `out_valid` cycles, in order, each matching the model `x+y+ci`.
- Backpressure: hold `out_ready`=0 with 2 beats in flight -> `in_ready`=0 and outputs frozen. Release -> both beats delivered in order, none lost or duplicated.
- With `PIPE_ADDER_SUB_EN`: `x`=0x10, `y`=0x20, `sub`=1, `ci`=0 -> `s`=0xF0, `co`=0. Without the macro, the same stimulus -> `s`=0x30.
- Assert `rst` for 1 cycle with 2 beats in flight -> `out_valid` stays 0 and all outputs are 0. The next beat after release appears after exactly STAGES cycles.
